// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the KGP instruction-fetch sequencer: FSM state
// encodings and default widths / reset PC used by fetch_sequencer and
// pc_update_reg.
package fetch_sequencer_pkg;

    localparam int          DEFAULT_ADDR_W   = 32;
    localparam int          DEFAULT_INSTR_W  = 32;
    localparam int          DEFAULT_CNT_W    = 32;
    localparam int unsigned DEFAULT_RESET_PC = 0;

    // Fetch controller states.
    typedef enum logic [1:0] {
        FS_FETCH = 2'd0,  // request at pc, waiting for imem_ack
        FS_DRAIN = 2'd1,  // redirected while a request was in flight; wait out the old ack
        FS_OUT   = 2'd2,  // instruction buffered, presented to decode
        FS_HALT  = 2'd3   // stopped until a redirect arrives
    } fetch_state_t;

endpackage

// File: rtl/pc_update_reg.sv
// Program counter register: synchronous reset to RESET_PC, load of a
// redirect target, or increment by one word. Load has priority over inc.
module pc_update_reg
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // PC update: reset, then redirect load, then sequential increment (wraps).
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for the KGP RISC core. Owns the PC, issues
// word-addressed imem reads over req/ack, buffers one instruction for decode
// over valid/ready, and applies execute redirects and halt.
// Optional feature: define FETCH_PERF_EN to add perf_fetch_cnt/perf_stall_cnt.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter int                INSTR_W  = DEFAULT_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
`ifdef FETCH_PERF_EN
    ,
    parameter int                CNT_W    = DEFAULT_CNT_W
`endif
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               halted
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0]   perf_fetch_cnt,
    output logic [CNT_W-1:0]   perf_stall_cnt
`endif
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] drain_addr;
    logic              accept;
    logic              capture;

    // A redirect in the OUT cycle cancels the handshake; a redirect in FETCH
    // discards any same-cycle read data.
    assign accept  = (state == FS_OUT) && if_ready && !redirect;
    assign capture = (state == FS_FETCH) && imem_ack && !redirect;

    pc_update_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (redirect),
        .load_pc  (redirect_pc),
        .inc      (accept),
        .pc       (pc)
    );

    // State register plus registered decode-facing status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FS_FETCH;
            if_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_next;
            if_valid <= (state_next == FS_OUT);
            halted   <= (state_next == FS_HALT);
        end
    end

    // Next-state logic; redirect outranks ack, ready and halt in every state.
    // NOTE: state_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            FS_FETCH: begin
                if (redirect) begin
                    state_next = imem_ack ? FS_FETCH : FS_DRAIN;
                end else if (imem_ack) begin
                    state_next = FS_OUT;
                end
            end
            FS_DRAIN: begin
                if (imem_ack) begin
                    state_next = FS_FETCH;
                end
            end
            FS_OUT: begin
                if (redirect) begin
                    state_next = FS_FETCH;
                end else if (if_ready) begin
                    state_next = halt ? FS_HALT : FS_FETCH;
                end
            end
            FS_HALT: begin
                if (redirect) begin
                    state_next = FS_FETCH;
                end
            end
            default: state_next = FS_FETCH;
        endcase
    end

    // Memory request outputs: the abandoned address is kept on the bus while draining.
    always_comb begin
        imem_req  = (state == FS_FETCH) || (state == FS_DRAIN);
        imem_addr = (state == FS_DRAIN) ? drain_addr : pc;
    end

    // Fetch buffer and the address of a request abandoned by a redirect.
    // NOTE: the instruction buffer is a plain register, not a RAM, and is
    // cleared on reset so decode never observes stale contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_instr   <= '0;
            if_pc      <= '0;
            drain_addr <= '0;
        end else begin
            if ((state == FS_FETCH) && redirect && !imem_ack) begin
                drain_addr <= pc;
            end
            if (capture) begin
                if_instr <= imem_rdata;
                if_pc    <= pc;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Performance counters: accepted instructions and decode back-pressure cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept) begin
                perf_fetch_cnt <= perf_fetch_cnt + CNT_W'(1);
            end
            if (if_valid && !if_ready) begin
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
